counter_dec_to_bin: RTL and testbench
=====================================

// Module: counter_dec_to_bin
// PURPOSE
//   Sequential BCD-to-binary decoder for the multi-digit decimal counter cascade.
//   Digit-serial Horner evaluation: acc = acc*10 + digit, MS digit first.
//   Sits downstream of the decimal counter: takes the parallel digit vector,
//   returns an unsigned binary value with a start/busy/done handshake.
// PARAMETERS
//   DIGITS  4   number of BCD digits in i_bcd (index 0 = least significant)
//   BIN_W   14  width of o_bin; must be >= ceil(log2(10**DIGITS)) (14 for 4 digits)
// PORTS
//   i_clk    in   1              system clock, rising edge
//   i_rst    in   1              asynchronous reset, active-low
//   i_bcd    in   [3:0] x DIGITS digit array, i_bcd[0] = units
//   i_start  in   1              conversion request, sampled in IDLE only
//   o_bin    out  BIN_W          last converted value, held until next o_done
//   o_busy   out  1              conversion in progress
//   o_done   out  1              one-cycle pulse: o_bin updated this cycle
//   o_err    out  1              invalid digit flag (only with BCD_CHECK_EN)
// BEHAVIOUR
//   Reset (i_rst=0, async): state=IDLE, o_bin=0, o_busy=0, o_done=0, o_err=0,
//     accumulator and digit index cleared. No done pulse emitted after release.
//   States: IDLE -> CONV -> IDLE.
//   IDLE: i_start=1 at edge k -> snapshot all i_bcd into shadow regs, acc=0,
//     idx=DIGITS-1, state=CONV, o_busy=1 from edge k.
//     i_bcd changes after edge k do not affect the conversion.
//   CONV: each edge: acc <= acc*10 + shadow[idx]; idx <= idx-1.
//     *10 implemented as (acc<<3)+(acc<<1), computed and truncated to BIN_W.
//     Digit added zero-extended to BIN_W.
//   Completion: at edge k+DIGITS the final acc is written to o_bin,
//     o_done=1 for exactly one cycle, o_busy=0, state=IDLE.
//   Latency: i_start sampled -> o_done high after exactly DIGITS clocks.
//   i_start while o_busy=1: ignored, not queued.
//   i_start high in the o_done cycle: accepted (state already IDLE),
//     giving back-to-back conversions every DIGITS+1 clocks.
//   i_start held high continuously: restarts on every IDLE cycle.
//   Reset mid-CONV: conversion aborted, o_bin returns to 0, no o_done.
//   Digits > 9 without checking: used arithmetically (0xA counts as ten).
// CONFIGURATION
//   `BCD_CHECK_EN defined:
//     o_err port present. Shadow digits checked at snapshot; any digit > 9
//     sets an internal error bit. o_err is written together with o_done
//     and held until the next o_done. o_bin is written as 0 when o_err=1.
//   `BCD_CHECK_EN undefined:
//     o_err port absent. No range check. o_bin written with the raw Horner result.
// TESTING
//   1. i_bcd={4,3,2,1} (d3..d0 = 1,2,3,4), pulse i_start -> o_done after 4 clks,
//      o_bin=1234, o_busy high exactly 4 clks.
//   2. {9,9,9,9} -> 9999 (0x270F). {0,0,0,0} -> 0. Both with o_done single pulse.
//   3. Start 0042, re-pulse i_start and change i_bcd to 7777 mid-CONV -> o_bin=42,
//      one o_done only.
//   4. i_start held high, i_bcd=0005 then 0500 -> o_done every 5 clks,
//      o_bin=5 then 500.
//   5. Start 8888, drop i_rst at CONV cycle 2 -> o_bin=0, o_busy=0,
//      no o_done after release.
//   6. (BCD_CHECK_EN) digits {0,0xA,1,2} -> o_err=1, o_bin=0; next start 0012
//      -> o_err=0, o_bin=12.

Source files
------------

// File: rtl/counter_dec_to_bin.sv
// rtl/counter_dec_to_bin.sv - digit-serial BCD-to-binary converter (acc = acc*10 + digit, MS digit first)
// Optional range check on the digits and the o_err port are enabled by defining BCD_CHECK_EN.
module counter_dec_to_bin #(
   parameter int DIGITS = 4,
   parameter int BIN_W  = 14
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic [DIGITS-1:0][3:0] i_bcd,
   input  logic                   i_start,
   output logic [BIN_W-1:0]       o_bin,
   output logic                   o_busy,
   output logic                   o_done
`ifdef BCD_CHECK_EN
   ,
   output logic                   o_err
`endif
);

   localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   typedef enum logic {
      IDLE = 1'b0,
      CONV = 1'b1
   } state_t;

   state_t                  state;
   state_t                  next_state;
   logic [DIGITS-1:0][3:0]  shadow;
   logic [BIN_W-1:0]        acc;
   logic [BIN_W-1:0]        acc_next;
   logic [IDX_W-1:0]        idx;
   logic [3:0]              digit;
   logic                    accept;
   logic                    last;

   assign accept   = (state == IDLE) && i_start;
   assign last     = (state == CONV) && (idx == '0);
   assign digit    = shadow[idx];
   // *10 as shift-add, wrapping at BIN_W bits
   assign acc_next = (acc << 3) + (acc << 1) + {{(BIN_W-4){1'b0}}, digit};
   assign o_busy   = (state == CONV);

`ifdef BCD_CHECK_EN
   logic bad_digit;
   logic err_pend;

   always_comb begin
      bad_digit = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         if (i_bcd[i] > 4'd9) begin
            bad_digit = 1'b1;
         end
      end
   end
`endif

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE: if (i_start) next_state = CONV;
         CONV: if (idx == '0) next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         shadow   <= '0;
         acc      <= '0;
         idx      <= '0;
         o_bin    <= '0;
         o_done   <= 1'b0;
`ifdef BCD_CHECK_EN
         err_pend <= 1'b0;
         o_err    <= 1'b0;
`endif
      end else begin
         o_done <= 1'b0;
         if (accept) begin
            shadow   <= i_bcd;
            acc      <= '0;
            idx      <= IDX_W'(DIGITS - 1);
`ifdef BCD_CHECK_EN
            err_pend <= bad_digit;
`endif
         end else if (state == CONV) begin
            acc <= acc_next;
            if (last) begin
               o_done <= 1'b1;
`ifdef BCD_CHECK_EN
               o_err  <= err_pend;
               o_bin  <= err_pend ? '0 : acc_next;
`else
               o_bin  <= acc_next;
`endif
            end else begin
               idx <= idx - 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_counter_dec_to_bin.sv
// tb/tb_counter_dec_to_bin.sv - randomized self-checking bench for counter_dec_to_bin against an arithmetic model
// Define BCD_CHECK_EN to also exercise the digit range check and o_err.
module tb_counter_dec_to_bin;
   localparam int DIGITS = 4;
   localparam int BIN_W  = 14;

   logic                   i_clk   = 1'b0;
   logic                   i_rst   = 1'b0;
   logic [DIGITS-1:0][3:0] i_bcd   = '0;
   logic                   i_start = 1'b0;
   logic [BIN_W-1:0]       o_bin;
   logic                   o_busy;
   logic                   o_done;
`ifdef BCD_CHECK_EN
   logic                   o_err;
`endif

   int checks   = 0;
   int failures = 0;
   int ndone    = 0;

   counter_dec_to_bin #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_bcd   (i_bcd),
      .i_start (i_start),
      .o_bin   (o_bin),
      .o_busy  (o_busy),
      .o_done  (o_done)
`ifdef BCD_CHECK_EN
      ,
      .o_err   (o_err)
`endif
   );

   always #5 i_clk = ~i_clk;

   // Reference: the decimal value of the digit vector, wrapped to BIN_W bits
   function automatic logic [BIN_W-1:0] bcd_value(input logic [DIGITS-1:0][3:0] d);
      int v = 0;
      int p = 1;
      for (int i = 0; i < DIGITS; i++) begin
         v = v + int'(d[i]) * p;
         p = p * 10;
      end
      return v[BIN_W-1:0];
   endfunction

   function automatic logic has_bad(input logic [DIGITS-1:0][3:0] d);
      for (int i = 0; i < DIGITS; i++) if (d[i] > 4'd9) return 1'b1;
      return 1'b0;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Model: countdown of remaining clocks, value captured at acceptance
   int               m_cnt      = 0;
   logic [BIN_W-1:0] m_val      = '0;
   logic [BIN_W-1:0] m_bin      = '0;
   logic             m_done     = 1'b0;
   logic             m_err      = 1'b0;
   logic             m_err_pend = 1'b0;

   always @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         m_cnt  = 0;
         m_bin  = '0;
         m_done = 1'b0;
         m_err  = 1'b0;
      end else begin
         m_done = 1'b0;
         if (m_cnt > 0) begin
            m_cnt = m_cnt - 1;
            if (m_cnt == 0) begin
               m_done = 1'b1;
`ifdef BCD_CHECK_EN
               m_err = m_err_pend;
               m_bin = m_err_pend ? '0 : m_val;
`else
               m_bin = m_val;
`endif
            end
         end else if (i_start) begin
            m_cnt      = DIGITS;
            m_val      = bcd_value(i_bcd);
            m_err_pend = has_bad(i_bcd);
         end
      end
   end

   always @(posedge i_clk) begin
      #2;
      check("bin", 32'(o_bin), 32'(m_bin));
      check("busy", 32'(o_busy), 32'(m_cnt > 0));
      check("done", 32'(o_done), 32'(m_done));
`ifdef BCD_CHECK_EN
      check("err", 32'(o_err), 32'(m_err));
`endif
      if (o_done === 1'b1) ndone++;
   end

   task automatic start_conv(input logic [DIGITS-1:0][3:0] d);
      @(negedge i_clk);
      i_bcd   = d;
      i_start = 1'b1;
      @(negedge i_clk);
      i_start = 1'b0;
   endtask

   task automatic wait_done(input string name, input int exp_lat, input logic [BIN_W-1:0] exp_bin);
      int n = 0;
      do begin
         @(posedge i_clk);
         #2;
         n++;
      end while (o_done !== 1'b1 && n < 20);
      check({name, "_lat"}, 32'(n), 32'(exp_lat));
      check({name, "_bin"}, 32'(o_bin), 32'(exp_bin));
   endtask

   initial begin
      int d0;
      int busy_n;
      repeat (3) @(negedge i_clk);
      check("rst_bin", 32'(o_bin), 32'd0);
      check("rst_busy", 32'(o_busy), 32'd0);
      check("rst_done", 32'(o_done), 32'd0);
      i_rst = 1'b1;
      repeat (2) @(negedge i_clk);

      // 1234, latency and busy width
      start_conv({4'd1, 4'd2, 4'd3, 4'd4});
      wait_done("t1234", DIGITS, 14'd1234);
      start_conv({4'd1, 4'd2, 4'd3, 4'd4});
      busy_n = 0;
      for (int i = 0; i < 8; i++) begin
         @(posedge i_clk);
         #2;
         if (o_busy === 1'b1) busy_n++;
      end
      check("busy_width", 32'(busy_n + 1), 32'(DIGITS));

      start_conv({4'd9, 4'd9, 4'd9, 4'd9});
      wait_done("t9999", DIGITS, 14'h270F);
      start_conv({4'd0, 4'd0, 4'd0, 4'd0});
      wait_done("t0000", DIGITS, 14'd0);

      // restart attempt and input change mid-conversion
      repeat (2) @(negedge i_clk);
      d0 = ndone;
      @(negedge i_clk);
      i_bcd   = {4'd0, 4'd0, 4'd4, 4'd2};
      i_start = 1'b1;
      @(negedge i_clk);
      i_bcd   = {4'd7, 4'd7, 4'd7, 4'd7};
      @(negedge i_clk);
      i_start = 1'b0;
      wait_done("t0042", DIGITS - 1, 14'd42);
      repeat (6) @(negedge i_clk);
      check("t0042_ndone", 32'(ndone - d0), 32'd1);

      // start held high: back-to-back every DIGITS+1 clocks
      @(negedge i_clk);
      i_bcd   = {4'd0, 4'd0, 4'd0, 4'd5};
      i_start = 1'b1;
      @(negedge i_clk);
      wait_done("hold5", DIGITS, 14'd5);
      i_bcd = {4'd0, 4'd5, 4'd0, 4'd0};
      wait_done("hold500", DIGITS + 1, 14'd500);
      i_start = 1'b0;
      repeat (8) @(negedge i_clk);

      // reset mid-conversion
      start_conv({4'd8, 4'd8, 4'd8, 4'd8});
      @(negedge i_clk);
      i_rst = 1'b0;
      #1;
      check("abort_bin", 32'(o_bin), 32'd0);
      check("abort_busy", 32'(o_busy), 32'd0);
      repeat (2) @(negedge i_clk);
      i_rst = 1'b1;
      d0 = ndone;
      repeat (10) @(negedge i_clk);
      check("abort_ndone", 32'(ndone - d0), 32'd0);

`ifdef BCD_CHECK_EN
      start_conv({4'd0, 4'hA, 4'd1, 4'd2});
      wait_done("bad", DIGITS, 14'd0);
      check("bad_err", 32'(o_err), 32'd1);
      start_conv({4'd0, 4'd0, 4'd1, 4'd2});
      wait_done("good12", DIGITS, 14'd12);
      check("good12_err", 32'(o_err), 32'd0);
`endif

      // randomized traffic, including out-of-range digits and rare resets
      for (int c = 0; c < 3000; c++) begin
         @(negedge i_clk);
         for (int i = 0; i < DIGITS; i++) begin
            i_bcd[i] = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15))
                                                   : 4'($urandom_range(0, 9));
         end
         i_start = ($urandom_range(0, 2) == 0);
         i_rst   = ($urandom_range(0, 399) != 0);
      end
      @(negedge i_clk);
      i_rst   = 1'b1;
      i_start = 1'b0;
      repeat (8) @(negedge i_clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
